// File: rtl/redirect_pkg.sv
// Shared types and age/coverage rules for the redirect arbiter.
// Ages compare the ROB wrap flag first, so wrap-around needs no extra handling.
package redirect_pkg;

    localparam int RD_IDX_W = 8;

    typedef struct packed {
        logic                flag;
        logic [RD_IDX_W-1:0] value;
        logic                level;
    } redirect_t;

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } state_e;

    function automatic logic is_older(input redirect_t a, input redirect_t b);
        if (a.flag == b.flag) begin
            return a.value < b.value;
        end
        return a.value > b.value;
    endfunction

    function automatic logic same_idx(input redirect_t a, input redirect_t b);
        return (a.flag == b.flag) && (a.value == b.value);
    endfunction

    // A held redirect covers anything younger, and an equal index unless the newcomer flushes more.
    function automatic logic covers(input redirect_t h, input redirect_t c);
        return is_older(h, c) || (same_idx(h, c) && (h.level || !c.level));
    endfunction

    function automatic logic wins_over(input redirect_t a, input redirect_t b);
        return is_older(a, b) || (same_idx(a, b) && a.level && !b.level);
    endfunction

endpackage

// File: rtl/redirect_oldest_sel.sv
// Combinational pick of the oldest valid redirect; equal candidates keep the lowest index.
module redirect_oldest_sel
    import redirect_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int ROB_IDX_W = RD_IDX_W,
    localparam int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ-1:0]           req_flag_i,
    input  logic [NUM_REQ*ROB_IDX_W-1:0] req_value_i,
    input  logic [NUM_REQ-1:0]           req_level_i,
    output logic                         win_valid_o,
    output logic [IDX_W-1:0]             win_idx_o,
    output redirect_t                    win_o
);

    redirect_t cand;

    always_comb begin
        win_valid_o = 1'b0;
        win_idx_o   = '0;
        win_o       = '0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand.flag  = req_flag_i[i];
            cand.value = req_value_i[i*ROB_IDX_W +: ROB_IDX_W];
            cand.level = req_level_i[i];
            if (req_valid_i[i] && (!win_valid_o || wins_over(cand, win_o))) begin
                win_valid_o = 1'b1;
                win_idx_o   = IDX_W'(i);
                win_o       = cand;
            end
        end
    end

endmodule

// File: rtl/redirect_arbiter.sv
// Merges redirect pulses onto one registered bus, suppressing requests already
// covered by the last issued redirect during a short flush window.
module redirect_arbiter
    import redirect_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ROB_IDX_W    = RD_IDX_W,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_robIdx_flag,
    input  logic [NUM_REQ*ROB_IDX_W-1:0] req_robIdx_value,
    input  logic [NUM_REQ-1:0]           req_level,
    output logic                         io_redirect_valid,
    output logic                         io_redirect_bits_robIdx_flag,
    output logic [ROB_IDX_W-1:0]         io_redirect_bits_robIdx_value,
    output logic                         io_redirect_bits_level,
    output logic                         busy,
    output logic [15:0]                  drop_cnt
);

    localparam int         IDX_W      = $clog2(NUM_REQ);
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    if (ROB_IDX_W != RD_IDX_W) begin : g_width_check
        $error("redirect_arbiter: ROB_IDX_W must equal redirect_pkg::RD_IDX_W");
    end

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    redirect_t          h_q, h_d;
    logic               vld_q, vld_d;
    logic [15:0]        drop_q, drop_d;

    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    redirect_t          win;
    logic               issue;
    logic [NUM_REQ-1:0] issued_mask;

    redirect_oldest_sel #(
        .NUM_REQ   (NUM_REQ),
        .ROB_IDX_W (ROB_IDX_W)
    ) u_sel (
        .req_valid_i (req_valid),
        .req_flag_i  (req_robIdx_flag),
        .req_value_i (req_robIdx_value),
        .req_level_i (req_level),
        .win_valid_o (win_valid),
        .win_idx_o   (win_idx),
        .win_o       (win)
    );

    // H doubles as the output bits register: both only change on an issue.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        h_d         = h_q;
        drop_d      = drop_q;
        issued_mask = '0;

        case (state_q)
            ST_IDLE:  issue = win_valid;
            ST_FLUSH: issue = win_valid && !covers(h_q, win);
            default:  issue = 1'b0;
        endcase
        vld_d = issue;

        if (issue) begin
            state_d              = ST_FLUSH;
            cnt_d                = FLUSH_LOAD;
            h_d                  = win;
            issued_mask[win_idx] = 1'b1;
        end else if (state_q == ST_FLUSH) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                state_d = ST_IDLE;
            end
        end

        if (((req_valid & ~issued_mask) != '0) && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            h_q     <= '0;
            vld_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            h_q     <= h_d;
            vld_q   <= vld_d;
            drop_q  <= drop_d;
        end
    end

    assign io_redirect_valid             = vld_q;
    assign io_redirect_bits_robIdx_flag  = h_q.flag;
    assign io_redirect_bits_robIdx_value = h_q.value;
    assign io_redirect_bits_level        = h_q.level;
    assign busy                          = (state_q == ST_FLUSH);
    assign drop_cnt                      = drop_q;

endmodule
